// File: rtl/mpsram_pkg.sv
// Shared types and helpers for the mpsram multi-port RAM: FSM encoding,
// lane-count derivation and the lane-merge function used by writes and bypass.
package mpsram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widest data word the merge helper handles; callers cast to/from this width.
  localparam int MAX_DW = 1024;

  function automatic int calc_nl(input int dw, input int lw);
    return dw / lw;
  endfunction

  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] sel,
    input int                lw
  );
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int b = 0; b < MAX_DW; b++) begin
      if (sel[10'(b / lw)]) m[b] = new_w[b];
    end
    return m;
  endfunction

endpackage

// File: rtl/mpsram_init.sv
// Post-reset clear sequencer for mpsram: walks every address once, then
// reports ready one edge after the last entry is written.
module mpsram_init
  import mpsram_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic          rdy_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = (state_q == ST_RUN);
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (&cnt_q) state_d = ST_RUN;
    end
  end

  assign we_o  = (state_q == ST_INIT);
  assign adr_o = cnt_q;
  assign rdy_o = rdy_q;

endmodule

// File: rtl/mpsram.sv
// Multi-port SRAM: one read/write port A plus NRD read-only X ports, lane write
// enables, registered reads. Define MPSRAM_BYPASS_EN for write-through reads.
module mpsram
  import mpsram_pkg::*;
#(
  parameter int             AW       = 5,
  parameter int             DW       = 32,
  parameter int             LW       = 8,
  parameter int             NRD      = 2,
  parameter logic [DW-1:0]  INIT_VAL = '0,
  localparam int            NL       = calc_nl(DW, LW)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ena_i,
  input  logic [AW-1:0]     adr_i,
  input  logic [DW-1:0]     dat_i,
  input  logic              wre_i,
  input  logic [NL-1:0]     sel_i,
  output logic [DW-1:0]     dat_o,
  input  logic [NRD*AW-1:0] xadr_i,
  output logic [NRD*DW-1:0] xdat_o,
  output logic              rdy_o
);

  logic [DW-1:0]     mem_q [2**AW];
  logic              init_we;
  logic [AW-1:0]     init_adr;
  logic              run;
  logic              wr_en;
  logic [DW-1:0]     wr_word;
  logic [DW-1:0]     dat_d, dat_q;
  logic [NRD*DW-1:0] xdat_d, xdat_q;

  mpsram_init #(.AW(AW)) u_init (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_o   (init_we),
    .adr_o  (init_adr),
    .rdy_o  (rdy_o)
  );

  assign run   = ~init_we;
  assign wr_en = run & ena_i & wre_i & (|sel_i);

  always_comb begin
    wr_word = DW'(lane_merge(MAX_DW'(mem_q[adr_i]), MAX_DW'(dat_i), MAX_DW'(sel_i), LW));
  end

  // Init sequencer owns the single write path until the clear completes.
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem_q[init_adr] <= INIT_VAL;
    end else if (wr_en) begin
      mem_q[adr_i] <= wr_word;
    end
  end

  always_comb begin
    dat_d  = mem_q[adr_i];
    xdat_d = '0;
    for (int n = 0; n < NRD; n++) begin
      xdat_d[n*DW +: DW] = mem_q[xadr_i[n*AW +: AW]];
    end
`ifdef MPSRAM_BYPASS_EN
    if (wr_en) dat_d = wr_word;
    for (int n = 0; n < NRD; n++) begin
      if (wr_en && (xadr_i[n*AW +: AW] == adr_i)) xdat_d[n*DW +: DW] = wr_word;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_q  <= '0;
      xdat_q <= '0;
    end else if (run && ena_i) begin
      dat_q  <= dat_d;
      xdat_q <= xdat_d;
    end
  end

  assign dat_o  = dat_q;
  assign xdat_o = xdat_q;

endmodule
